// File: rtl/demux4_stream_if.sv
// Stream bundle for demux4_stream: one producer-side input stream and four
// consumer channels, each with data, valid and ready.
interface demux4_stream_if #(parameter int W = 8);
  logic [W-1:0] d;
  logic         d_valid;
  logic         d_ready;
  logic [1:0]   s;
  logic [1:0]   cur_s;
  logic [W-1:0] q0, q1, q2, q3;
  logic         v0, v1, v2, v3;
  logic         r0, r1, r2, r3;

  modport master (
    output d, d_valid, s, r0, r1, r2, r3,
    input  d_ready, cur_s, q0, q1, q2, q3, v0, v1, v2, v3
  );

  modport slave (
    input  d, d_valid, s, r0, r1, r2, r3,
    output d_ready, cur_s, q0, q1, q2, q3, v0, v1, v2, v3
  );
endinterface

// File: rtl/demux4_stream.sv
// Registered 1:4 stream demultiplexer with a 2-entry FIFO per channel.
// Define AUTO_SEL_EN to deal beats round-robin instead of using s.
module demux4_stream #(
  parameter int W = 8
) (
  input logic            clk,
  input logic            rst_n,
  demux4_stream_if.slave bus
);

  logic [W-1:0] mem [4][2];
  logic [W-1:0] last_q [4];
  logic [W-1:0] head [4];
  logic [1:0]   cnt [4];
  logic [3:0]   rd_ptr;
  logic [3:0]   wr_ptr;
  logic [3:0]   r_vec;
  logic [3:0]   nonempty;
  logic [3:0]   push_vec;
  logic [3:0]   pop_vec;
  logic [1:0]   sel;
  logic         ready;
  logic         push;

  assign r_vec = {bus.r3, bus.r2, bus.r1, bus.r0};

`ifdef AUTO_SEL_EN
  logic [1:0] sel_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_ptr <= '0;
    end else if (push) begin
      sel_ptr <= sel_ptr + 2'd1;
    end
  end

  assign sel = sel_ptr;
`else
  assign sel = bus.s;
`endif

  // An empty channel keeps presenting its previous head rather than a stale slot.
  always_comb begin
    nonempty = '0;
    pop_vec  = '0;
    push_vec = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      nonempty[k] = (cnt[k] != 2'd0);
      pop_vec[k]  = nonempty[k] & r_vec[k];
      head[k]     = nonempty[k] ? mem[k][rd_ptr[k]] : last_q[k];
    end
    ready         = (cnt[sel] != 2'd2);
    push          = bus.d_valid & ready;
    push_vec[sel] = push;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int unsigned k = 0; k < 4; k++) begin
        cnt[k]    <= '0;
        last_q[k] <= '0;
        mem[k][0] <= '0;
        mem[k][1] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < 4; k++) begin
        last_q[k] <= head[k];
        if (push_vec[k]) begin
          mem[k][wr_ptr[k]] <= bus.d;
          wr_ptr[k]         <= ~wr_ptr[k];
        end
        if (pop_vec[k]) begin
          rd_ptr[k] <= ~rd_ptr[k];
        end
        if (push_vec[k] && !pop_vec[k]) begin
          cnt[k] <= cnt[k] + 2'd1;
        end else if (!push_vec[k] && pop_vec[k]) begin
          cnt[k] <= cnt[k] - 2'd1;
        end
      end
    end
  end

  assign bus.d_ready = ready;
  assign bus.cur_s   = sel;
  assign bus.q0      = head[0];
  assign bus.q1      = head[1];
  assign bus.q2      = head[2];
  assign bus.q3      = head[3];
  assign bus.v0      = nonempty[0];
  assign bus.v1      = nonempty[1];
  assign bus.v2      = nonempty[2];
  assign bus.v3      = nonempty[3];

endmodule
